// File: rtl/mrd_pkg.sv
// Shared defaults and state encoding for the detected-vector streaming slice.
package mrd_pkg;
  localparam int DEF_DIMENSION = 16;
  localparam int DEF_WIDTH     = 8;
  localparam int IDX_W         = $clog2(DEF_DIMENSION);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/x_slicer.sv
// Per-element decision on the out_data path. Pass-through by default;
// X_HARD_SLICE_EN turns it into a +1/-1 hard decision.
module x_slicer
  import mrd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

`ifdef X_HARD_SLICE_EN
  // Zero counts as non-negative and maps to +1.
  function automatic logic signed [WIDTH-1:0] hard_decide(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign dout = hard_decide(din);
`else
  assign dout = din;
`endif

endmodule

// File: rtl/x_stream_out.sv
// Serialises a captured DIMENSION-element vector into one beat per element
// with valid/ready handshake. Optional X_HARD_SLICE_EN hard-decides each element.
module x_stream_out
  import mrd_pkg::*;
#(
  parameter int DIMENSION = DEF_DIMENSION,
  parameter int WIDTH     = DEF_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         x_valid,
  input  logic [DIMENSION*WIDTH-1:0]   x_final,
  output logic                         x_ready,
  output logic signed [WIDTH-1:0]      out_data,
  output logic [$clog2(DIMENSION)-1:0] out_index,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         ovf
);

  localparam int                  IDX_BITS = $clog2(DIMENSION);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DIMENSION - 1);
  localparam logic [0:0]          S_IDLE   = 1'(IDLE);
  localparam logic [0:0]          S_SEND   = 1'(SEND);

  logic [0:0]                 state_p0;
  logic [IDX_BITS-1:0]        idx_p0;
  logic [DIMENSION*WIDTH-1:0] elem_buf_p0;
  logic                       primed_p0;

  logic                    in_send;
  logic                    at_last;
  logic                    beat_xfer;
  logic                    capture;
  logic signed [WIDTH-1:0] elem_sel;
  logic signed [WIDTH-1:0] elem_dec;

  // A new vector may be taken while the final beat of the previous one drains.
  assign in_send   = (state_p0 == S_SEND);
  assign at_last   = (idx_p0 == LAST_IDX);
  assign x_ready   = en && (!in_send || (at_last && out_ready));
  assign out_valid = en && in_send;
  assign beat_xfer = out_valid && out_ready;
  assign capture   = x_valid && x_ready;

  // ---- stage p0: captured buffer and index drive the outputs directly ----
  // idx stays on the last element when returning to IDLE, so the outputs
  // hold their final values without extra registers.
  assign elem_sel = elem_buf_p0[idx_p0*WIDTH +: WIDTH];

  x_slicer #(
    .WIDTH(WIDTH)
  ) u_slicer (
    .din (elem_sel),
    .dout(elem_dec)
  );

  // primed_p0 keeps out_data at zero until the first vector arrives,
  // which matters when the slicer would turn a zero buffer into +1.
  assign out_data  = primed_p0 ? elem_dec : '0;
  assign out_index = idx_p0;
  assign out_last  = at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= S_IDLE;
      idx_p0      <= '0;
      elem_buf_p0 <= '0;
      primed_p0   <= 1'b0;
      ovf         <= 1'b0;
    end else if (en) begin
      if (capture) begin
        elem_buf_p0 <= x_final;
        idx_p0      <= '0;
        state_p0    <= S_SEND;
        primed_p0   <= 1'b1;
      end else if (beat_xfer) begin
        if (at_last) begin
          state_p0 <= S_IDLE;
        end else begin
          idx_p0 <= idx_p0 + IDX_BITS'(1);
        end
      end
      if (x_valid && !x_ready) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/x_stream_out.md
X_STREAM_OUT -- requirements
Module: x_stream_out

Interface
REQ-001 The module SHALL have parameter DIMENSION, default 16, giving the number of elements per detected vector.
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the bits per signed element.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  global enable
- x_valid  in  1  x_final is final and may be captured
- x_final  in  DIMENSION*WIDTH  signed detected vector; element k (k=0..DIMENSION-1) is bits [k*WIDTH+:WIDTH]
- x_ready  out  1  block can accept a vector this cycle
- out_data  out  WIDTH  current element
- out_index  out  $clog2(DIMENSION)  index of out_data
- out_valid  out  1  out_data is valid
- out_last  out  1  current beat is element DIMENSION-1
- out_ready  in  1  downstream accepts the beat
- ovf  out  1  sticky flag: a vector was offered while not accepted

Function
REQ-005 The FSM SHALL have two states, IDLE and SEND.
REQ-006 x_ready SHALL be en AND (state==IDLE OR (state==SEND AND idx==DIMENSION-1 AND out_ready)).
REQ-007 When x_valid AND x_ready are high, the block SHALL copy x_final into an internal buffer, clear idx to 0, and enter SEND at the next edge.
REQ-008 In SEND, out_valid SHALL be en. out_data SHALL be buf[idx]. out_index SHALL be idx. out_last SHALL be (idx==DIMENSION-1).
REQ-009 A beat SHALL transfer when out_valid AND out_ready are high. idx SHALL then increment by 1.
REQ-010 On transfer of the last beat, the block SHALL return to IDLE, unless REQ-007 captures a new vector in the same cycle. In that case it SHALL stay in SEND with idx=0, giving back-to-back vectors with no bubble.
REQ-011 In IDLE, out_valid SHALL be 0. out_data, out_index and out_last SHALL hold their last values.
REQ-012 First-beat latency SHALL be one cycle: capture at edge N, out_valid high in the cycle after edge N.
REQ-013 While out_valid is high and out_ready is low, out_data, out_index and out_last SHALL be stable.
REQ-014 When en is low, the block SHALL make no state, idx, buffer or ovf change, and out_valid SHALL be 0. When en returns high, sending SHALL resume at the same idx.
REQ-015 x_valid high while x_ready is low (with en high) SHALL set ovf. The offered vector SHALL be dropped and the buffer left unchanged.
REQ-016 x_final changes outside a capture cycle SHALL NOT affect beats in flight.

Reset
REQ-017 When rst is high at an edge, all of the following SHALL be set: state=IDLE, idx=0, buffer=0, ovf=0, out_data=0, out_index=0, out_last=0, out_valid=0.
REQ-018 rst SHALL take priority over en and all handshakes. A reset during SEND SHALL abandon the vector with no further beats.

Configuration
REQ-019 With macro X_HARD_SLICE_EN defined, out_data SHALL be a hard decision: +1 (0x01) if buf[idx]>=0, else -1 (all ones).
REQ-020 Without X_HARD_SLICE_EN, out_data SHALL be buf[idx] unchanged, as WIDTH-bit two's complement.
REQ-021 The macro SHALL affect only the out_data value path, never timing or handshake.

Structure
REQ-022 Package mrd_pkg SHALL hold:
- DIMENSION and WIDTH defaults
- IDX_W = $clog2(DIMENSION)
- the state enum {IDLE, SEND}
REQ-023 The element decision SHALL be one combinational sub-module, x_slicer (WIDTH in, WIDTH out), instantiated on the out_data path. It SHALL be pass-through when X_HARD_SLICE_EN is undefined.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset then idle: outputs all 0, x_ready=1 when en=1.
- Single vector, element k = k-8, out_ready held 1: 16 beats on consecutive cycles with out_data -8..7 and out_index 0..15, out_last only on beat 15. Slice build: out_data FF for k<8, 01 for k>=8.
- Backpressure: out_ready toggling 1,0 each cycle: each element appears exactly once, data stable while stalled, 32 cycles total.
- Back-to-back: second x_valid on the last-beat cycle: second vector's beat 0 on the next cycle, no gap, ovf=0.
- Overflow: x_valid during beat 5: ovf=1, first vector intact, second dropped. rst clears ovf.
- en low at beat 7 for 3 cycles: out_valid=0 for those cycles, then beat 7 resumes with no loss or duplication. A rst pulse mid-SEND gives out_valid=0 on the next cycle.
